ddr_init_sequencer: RTL and testbench

- Generates the DDR4 power-up and initialization command stream on the DDR interface pins.
- Sequence: hold reset_n low, release reset_n, raise CKE, issue MRS3/6/5/4/2/1/0, issue ZQCL, wait tZQ, then flag completion.
- Sits directly upstream of the DDR protocol checker. It drives the same pin group that the checker samples.
- Hands the bus to the command scheduler through init_done. The scheduler must not issue ACT until init_done=1.

---
 rtl/ddr_init_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ddr_init_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_sequencer.sv
// DDR4 power-up/initialisation command sequencer: reset, CKE, MRS3/6/5/4/2/1/0, ZQCL, tZQ, done.
// Optional DDR_INIT_RESTART_EN adds a 'restart' input that re-runs the sequence from DONE.
module ddr_init_sequencer #(
  parameter int unsigned T_RST   = 20,
  parameter int unsigned T_CKE_L = 50,
  parameter int unsigned T_IS    = 1,
  parameter int unsigned T_XPR   = 10,
  parameter int unsigned T_MRD   = 8,
  parameter int unsigned T_MOD   = 24,
  parameter int unsigned T_ZQ    = 512,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clock_t,
  input  logic        reset_n,
`ifdef DDR_INIT_RESTART_EN
  input  logic        restart,
`endif
  output logic [2:0]  mr_idx,
  input  logic [13:0] mr_value,
  output logic        ddr_reset_n,
  output logic        cke,
  output logic        cs_n,
  output logic        act_n,
  output logic        ras_n_a16,
  output logic        cas_n_a15,
  output logic        we_n_a14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [13:0] addr,
  output logic        init_done
);

  localparam longint unsigned MaxCnt = 64'(1) << CNT_W;

  if (T_RST == 0 || T_CKE_L == 0 || T_IS == 0 || T_XPR == 0 || T_MRD == 0 || T_MOD == 0 ||
      T_ZQ == 0) begin : g_zero_param
    $error("ddr_init_sequencer: delay parameters must be non-zero");
  end
  // The wait after an MRS needs one cycle so the next mr_idx reaches the config block.
  if (T_MRD < 2 || T_MOD < 2) begin : g_short_gap
    $error("ddr_init_sequencer: T_MRD and T_MOD must be at least 2");
  end
  if (64'(T_RST) >= MaxCnt || 64'(T_CKE_L) >= MaxCnt || 64'(T_IS) + 64'(T_XPR) >= MaxCnt ||
      64'(T_MRD) >= MaxCnt || 64'(T_MOD) >= MaxCnt || 64'(T_ZQ) >= MaxCnt) begin : g_cnt_width
    $error("ddr_init_sequencer: delay parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LdRst = CNT_W'(T_RST);
  localparam logic [CNT_W-1:0] LdCke = CNT_W'(T_CKE_L);
  localparam logic [CNT_W-1:0] LdXpr = CNT_W'(T_IS + T_XPR);
  localparam logic [CNT_W-1:0] LdMrd = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LdMod = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LdZq  = CNT_W'(T_ZQ);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  // {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}
  localparam logic [4:0] CmdDes  = 5'b11111;
  localparam logic [4:0] CmdMrs  = 5'b01000;
  localparam logic [4:0] CmdZqcl = 5'b01110;

  typedef enum logic [3:0] {
    StRstLow, StCkeWait, StXprWait, StMrs, StMrdWait, StModWait, StZqcl, StZqWait, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         mr_idx_q, mr_idx_d;
  logic               rstn_q, rstn_d, cke_q, cke_d, done_q, done_d;
  logic [4:0]         cmd_q, cmd_d;
  logic [1:0]         bg_q, bg_d, ba_q, ba_d;
  logic [13:0]        addr_q, addr_d;
  logic               expire;
  logic [2:0]         mr_next;

  assign expire = (cnt_q == One);

  always_comb begin
    case (mr_idx_q)
      3'd3:    mr_next = 3'd6;
      3'd6:    mr_next = 3'd5;
      3'd5:    mr_next = 3'd4;
      3'd4:    mr_next = 3'd2;
      3'd2:    mr_next = 3'd1;
      default: mr_next = 3'd0;
    endcase
  end

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      state_q  <= StRstLow;
      cnt_q    <= '0;
      mr_idx_q <= 3'd3;
      rstn_q   <= 1'b0;
      cke_q    <= 1'b0;
      done_q   <= 1'b0;
      cmd_q    <= CmdDes;
      bg_q     <= '0;
      ba_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mr_idx_q <= mr_idx_d;
      rstn_q   <= rstn_d;
      cke_q    <= cke_d;
      done_q   <= done_d;
      cmd_q    <= cmd_d;
      bg_q     <= bg_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
    end
  end

  // Each wait state leaves exactly N edges after the edge that loaded N.
  always_comb begin
    state_d  = state_q;
    mr_idx_d = mr_idx_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - One : cnt_q;
    unique case (state_q)
      StRstLow: begin
        if (cnt_q == '0) begin
          cnt_d = LdRst;
        end else if (expire) begin
          state_d = StCkeWait;
          cnt_d   = LdCke;
        end
      end
      StCkeWait: if (expire) begin
        state_d = StXprWait;
        cnt_d   = LdXpr;
      end
      StXprWait: if (expire) state_d = StMrs;
      StMrs: begin
        if (mr_idx_q == 3'd0) begin
          state_d = StModWait;
          cnt_d   = LdMod;
        end else begin
          state_d  = StMrdWait;
          cnt_d    = LdMrd;
          mr_idx_d = mr_next;
        end
      end
      StMrdWait: if (expire) state_d = StMrs;
      StModWait: if (expire) state_d = StZqcl;
      StZqcl: begin
        state_d = StZqWait;
        cnt_d   = LdZq;
      end
      StZqWait: if (expire) state_d = StDone;
      StDone: begin
`ifdef DDR_INIT_RESTART_EN
        if (restart) begin
          state_d  = StRstLow;
          cnt_d    = LdRst;
          mr_idx_d = 3'd3;
        end
`endif
      end
      default: begin
        state_d = StRstLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins are registered from the next state, so a command shows the cycle after its decision.
  always_comb begin
    rstn_d = (state_d != StRstLow);
    cke_d  = !(state_d inside {StRstLow, StCkeWait});
    done_d = (state_d == StDone);
    cmd_d  = CmdDes;
    bg_d   = '0;
    ba_d   = '0;
    addr_d = '0;
    case (state_d)
      StMrs: begin
        cmd_d  = CmdMrs;
        bg_d   = {1'b0, mr_idx_q[2]};
        ba_d   = mr_idx_q[1:0];
        addr_d = mr_value;
      end
      StZqcl: begin
        cmd_d  = CmdZqcl;
        addr_d = 14'h0400;
      end
      default: ;
    endcase
  end

  assign mr_idx      = mr_idx_q;
  assign ddr_reset_n = rstn_q;
  assign cke         = cke_q;
  assign init_done   = done_q;
  assign {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} = cmd_q;
  assign bg_addr     = bg_q;
  assign ba_addr     = ba_q;
  assign addr        = addr_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Scoreboard bench for ddr_init_sequencer: default instance (u_a) and a short-timing instance (u_b).
module tb_ddr_init_sequencer;

  localparam int EvRst  = 0;
  localparam int EvCke  = 1;
  localparam int EvMrs  = 2;
  localparam int EvZq   = 3;
  localparam int EvDone = 4;
  localparam int EvBad  = 5;
  localparam int EvAct  = 6;

  typedef struct packed {
    int          kind;
    int          cyc;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] addr;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
`ifdef DDR_INIT_RESTART_EN
  logic restart_a = 1'b0;
  logic restart_b = 1'b0;
`endif

  logic [2:0]  a_idx, b_idx;
  logic [13:0] a_val, b_val, a_addr, b_addr;
  logic        a_rn, a_cke, a_cs, a_act, a_ras, a_cas, a_we, a_done;
  logic        b_rn, b_cke, b_cs, b_act, b_ras, b_cas, b_we, b_done;
  logic [1:0]  a_bg, a_ba, b_bg, b_ba;

  function automatic logic [13:0] mr_val(input logic [2:0] idx);
    if (idx == 3'd5) return 14'h0A5A;
    return {idx, 11'h135};
  endfunction

  assign a_val = mr_val(a_idx);
  assign b_val = mr_val(b_idx);

  ddr_init_sequencer u_a (
    .clock_t(clk), .reset_n(rst_a_n),
`ifdef DDR_INIT_RESTART_EN
    .restart(restart_a),
`endif
    .mr_idx(a_idx), .mr_value(a_val), .ddr_reset_n(a_rn), .cke(a_cke), .cs_n(a_cs),
    .act_n(a_act), .ras_n_a16(a_ras), .cas_n_a15(a_cas), .we_n_a14(a_we), .bg_addr(a_bg),
    .ba_addr(a_ba), .addr(a_addr), .init_done(a_done)
  );

  ddr_init_sequencer #(.T_MRD(4), .T_XPR(5), .T_ZQ(16)) u_b (
    .clock_t(clk), .reset_n(rst_b_n),
`ifdef DDR_INIT_RESTART_EN
    .restart(restart_b),
`endif
    .mr_idx(b_idx), .mr_value(b_val), .ddr_reset_n(b_rn), .cke(b_cke), .cs_n(b_cs),
    .act_n(b_act), .ras_n_a16(b_ras), .cas_n_a15(b_cas), .we_n_a14(b_we), .bg_addr(b_bg),
    .ba_addr(b_ba), .addr(b_addr), .init_done(b_done)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  int   ca = 0;
  int   cb = 0;
  int   last_ea = -1;
  logic prev_r[2] = '{1'b0, 1'b0};
  logic prev_c[2] = '{1'b0, 1'b0};
  logic prev_d[2] = '{1'b0, 1'b0};

  // Cycle numbers count edges since reset release: edge 0 is the first with reset_n=1.
  task automatic observe(input int id, input int e, input logic rn, input logic ck,
                         input logic dn, input logic cs, input logic act, input logic ras,
                         input logic cas, input logic we, input logic [1:0] bg,
                         input logic [1:0] ba, input logic [13:0] ad);
    ev_t o;
    if (e >= 0) begin
      o = '{kind: EvRst, cyc: e, bg: 2'b0, ba: 2'b0, addr: 14'h0};
      if (rn && !prev_r[id]) obs_q.push_back(o);
      o.kind = EvCke;
      if (ck && !prev_c[id]) obs_q.push_back(o);
      if (!cs) begin
        if (!act) o.kind = EvAct;
        else if (!ras && !cas && !we) o.kind = EvMrs;
        else if (ras && cas && !we) o.kind = EvZq;
        else o.kind = EvBad;
        o.bg = bg; o.ba = ba; o.addr = ad;
        obs_q.push_back(o);
        o.bg = 2'b0; o.ba = 2'b0; o.addr = 14'h0;
      end
      o.kind = EvDone;
      if (dn && !prev_d[id]) obs_q.push_back(o);
    end
    prev_r[id] = rn; prev_c[id] = ck; prev_d[id] = dn;
  endtask

  task automatic tick();
    int ea, eb;
    @(posedge clk);
    ea = rst_a_n ? ca : -1;
    ca = rst_a_n ? ca + 1 : 0;
    eb = rst_b_n ? cb : -1;
    cb = rst_b_n ? cb + 1 : 0;
    if (ea >= 0) last_ea = ea;
    @(negedge clk);
    observe(0, ea, a_rn, a_cke, a_done, a_cs, a_act, a_ras, a_cas, a_we, a_bg, a_ba, a_addr);
    observe(1, eb, b_rn, b_cke, b_done, b_cs, b_act, b_ras, b_cas, b_we, b_bg, b_ba, b_addr);
  endtask

  // Expected event list derived from the timing parameters (T_RST=20, T_CKE_L=50, T_IS=1, T_MOD=24).
  task automatic push_seq(input int base, input int xpr, input int mrd, input int zq);
    int         order[7] = '{3, 6, 5, 4, 2, 1, 0};
    int         c;
    logic [2:0] idx;
    ev_t        e;
    c = base + 20;
    e = '{kind: EvRst, cyc: c, bg: 2'b0, ba: 2'b0, addr: 14'h0};
    exp_q.push_back(e);
    c += 50;
    e.kind = EvCke; e.cyc = c;
    exp_q.push_back(e);
    c += 1 + xpr;
    for (int i = 0; i < 7; i++) begin
      idx = 3'(order[i]);
      e = '{kind: EvMrs, cyc: c, bg: {1'b0, idx[2]}, ba: idx[1:0], addr: mr_val(idx)};
      exp_q.push_back(e);
      if (i < 6) c += mrd;
    end
    c += 24;
    e = '{kind: EvZq, cyc: c, bg: 2'b0, ba: 2'b0, addr: 14'h0400};
    exp_q.push_back(e);
    c += zq + 1;
    e = '{kind: EvDone, cyc: c, bg: 2'b0, ba: 2'b0, addr: 14'h0};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({a_rn, a_cke, a_done, a_cs, a_act, a_ras, a_cas, a_we} !== 8'b000_11111) begin
      n_fail++;
      $display("FAIL reset_pins_a: got %b, expected 00011111",
               {a_rn, a_cke, a_done, a_cs, a_act, a_ras, a_cas, a_we});
    end
    n_cmp++;
    if ({a_idx, a_bg, a_ba, a_addr} !== {3'd3, 18'h0}) begin
      n_fail++;
      $display("FAIL reset_bus_a: got idx=%0d bg=%0d ba=%0d addr=%h, expected idx=3 rest 0",
               a_idx, a_bg, a_ba, a_addr);
    end
    n_cmp++;
    if ({b_rn, b_cke, b_done, b_cs, b_idx} !== {4'b0001, 3'd3}) begin
      n_fail++;
      $display("FAIL reset_b: got rn=%b cke=%b done=%b cs=%b idx=%0d, expected 0 0 0 1 3",
               b_rn, b_cke, b_done, b_cs, b_idx);
    end
    obs_q.delete();
  endtask

  task automatic test_full_sequence();
    ev_t o, e;
    exp_q.delete();
    push_seq(0, 10, 8, 512);
    rst_a_n = 1'b1;
    for (int i = 0; i < 720 && exp_q.size() > 0; i++) begin
      tick();
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL full_seq extra: got kind=%0d cyc=%0d, expected no event", o.kind, o.cyc);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL full_seq event: got kind=%0d cyc=%0d bg=%0d ba=%0d addr=%h, expected kind=%0d cyc=%0d bg=%0d ba=%0d addr=%h",
                     o.kind, o.cyc, o.bg, o.ba, o.addr, e.kind, e.cyc, e.bg, e.ba, e.addr);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL full_seq timeout: got %0d events missing, expected 0", exp_q.size());
    end
    repeat (40) tick();
    n_cmp++;
    if (obs_q.size() !== 0 || a_done !== 1'b1 || a_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL full_seq done_hold: got %0d extra events done=%b cs_n=%b, expected 0 1 1",
               obs_q.size(), a_done, a_cs);
    end
    obs_q.delete();
  endtask

  task automatic test_sweep();
    ev_t o, e;
    exp_q.delete();
    push_seq(0, 5, 4, 16);
    rst_b_n = 1'b1;
    for (int i = 0; i < 250 && exp_q.size() > 0; i++) begin
      tick();
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sweep extra: got kind=%0d cyc=%0d, expected no event", o.kind, o.cyc);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL sweep event: got kind=%0d cyc=%0d bg=%0d ba=%0d addr=%h, expected kind=%0d cyc=%0d bg=%0d ba=%0d addr=%h",
                     o.kind, o.cyc, o.bg, o.ba, o.addr, e.kind, e.cyc, e.bg, e.ba, e.addr);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0 || b_done !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep timeout: got %0d events missing done=%b, expected 0 1",
               exp_q.size(), b_done);
    end
    obs_q.delete();
  endtask

  task automatic test_mid_reset();
    ev_t o, e;
    rst_a_n = 1'b0;
    repeat (2) tick();
    obs_q.delete();
    exp_q.delete();
    push_seq(0, 10, 8, 512);
    rst_a_n = 1'b1;
    // Run to edge 108: MRS4 went out at 105, MRS2 is not due until 113.
    for (int i = 0; i < 200 && ca < 109; i++) begin
      tick();
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL mid_reset pre: got kind=%0d cyc=%0d addr=%h, expected kind=%0d cyc=%0d addr=%h",
                   o.kind, o.cyc, o.addr, e.kind, e.cyc, e.addr);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 5) begin
      n_fail++;
      $display("FAIL mid_reset progress: got %0d events pending, expected 5", exp_q.size());
    end
    rst_a_n = 1'b0;
    tick();
    n_cmp++;
    if ({a_rn, a_cke, a_done, a_cs, a_idx} !== {4'b0001, 3'd3}) begin
      n_fail++;
      $display("FAIL mid_reset state: got rn=%b cke=%b done=%b cs=%b idx=%0d, expected 0 0 0 1 3",
               a_rn, a_cke, a_done, a_cs, a_idx);
    end
    exp_q.delete();
    obs_q.delete();
    push_seq(0, 10, 8, 512);
    rst_a_n = 1'b1;
    for (int i = 0; i < 720 && exp_q.size() > 0; i++) begin
      tick();
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mid_reset extra: got kind=%0d cyc=%0d, expected no event", o.kind, o.cyc);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL mid_reset rerun: got kind=%0d cyc=%0d addr=%h, expected kind=%0d cyc=%0d addr=%h",
                     o.kind, o.cyc, o.addr, e.kind, e.cyc, e.addr);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() !== 0 || a_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset timeout: got %0d events missing done=%b, expected 0 1",
               exp_q.size(), a_done);
    end
    obs_q.delete();
  endtask

`ifdef DDR_INIT_RESTART_EN
  task automatic test_restart();
    ev_t o, e;
    int  base;
    restart_a = 1'b1;
    tick();
    restart_a = 1'b0;
    base = last_ea;
    n_cmp++;
    if ({a_done, a_cke, a_rn} !== 3'b000) begin
      n_fail++;
      $display("FAIL restart_drop: got done=%b cke=%b rn=%b, expected 0 0 0", a_done, a_cke, a_rn);
    end
    exp_q.delete();
    obs_q.delete();
    push_seq(base, 10, 8, 512);
    for (int i = 0; i < 720 && exp_q.size() > 0; i++) begin
      tick();
      restart_a = (ca == base + 300); // lands in ZQ_WAIT, must be ignored
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL restart extra: got kind=%0d cyc=%0d, expected no event", o.kind, o.cyc);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL restart rerun: got kind=%0d cyc=%0d addr=%h, expected kind=%0d cyc=%0d addr=%h",
                     o.kind, o.cyc, o.addr, e.kind, e.cyc, e.addr);
          end
        end
      end
    end
    restart_a = 1'b0;
    n_cmp++;
    if (exp_q.size() !== 0 || a_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart timeout: got %0d events missing done=%b, expected 0 1",
               exp_q.size(), a_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_sequence();
    test_sweep();
    test_mid_reset();
`ifdef DDR_INIT_RESTART_EN
    test_restart();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
